// File: rtl/low_pass_divider.sv
// Fully pipelined unsigned 24/8 restoring divider, one result per cycle, fixed
// 26-cycle latency, no back-pressure. Output word is {quotient, remainder}.
module low_pass_divider (
    input  logic        aclk,
    input  logic        rst_i,
    input  logic        s_axis_divisor_tvalid,
    input  logic [7:0]  s_axis_divisor_tdata,
    input  logic        s_axis_dividend_tvalid,
    input  logic [23:0] s_axis_dividend_tdata,
    output logic        m_axis_dout_tvalid,
    output logic [31:0] m_axis_dout_tdata
);
    localparam int DIVIDEND_WIDTH = 24;
    localparam int DIVISOR_WIDTH  = 8;
    localparam int STAGES         = DIVIDEND_WIDTH;

    // Index 0 is the input register; index k holds the state after k quotient bits.
    // The dividend register shifts quotient bits in at the LSB as dividend bits leave the MSB.
    logic                      vld_q [0:STAGES] = '{default: 1'b0};
    logic [DIVIDEND_WIDTH-1:0] dvd_q [0:STAGES] = '{default: '0};
    logic [DIVISOR_WIDTH-1:0]  dsr_q [0:STAGES] = '{default: '0};
    logic [DIVISOR_WIDTH-1:0]  rem_q [0:STAGES] = '{default: '0};

    logic                      fix_vld_q  = 1'b0;
    logic [31:0]               fix_data_q = '0;
    logic                      out_vld_q  = 1'b0;
    logic [31:0]               out_data_q = '0;

    logic                      take_d     [0:STAGES-1];
    logic [DIVISOR_WIDTH-1:0]  rem_d      [0:STAGES-1];
    logic [DIVISOR_WIDTH:0]    trial      [0:STAGES-1];
    logic [31:0]               fix_data_d;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            // Partial remainder is one bit wider than the divisor so the trial cannot overflow.
            trial[k]  = {rem_q[k], dvd_q[k][DIVIDEND_WIDTH-1]};
            take_d[k] = (trial[k] >= {1'b0, dsr_q[k]});
            rem_d[k]  = take_d[k] ? DIVISOR_WIDTH'(trial[k] - {1'b0, dsr_q[k]})
                                  : trial[k][DIVISOR_WIDTH-1:0];
        end
    end

    // A zero divisor yields all-ones quotient naturally, but the remainder is forced to zero.
    always_comb begin
        fix_data_d = {dvd_q[STAGES], rem_q[STAGES]};
        if (dsr_q[STAGES] == '0) begin
            fix_data_d = {{DIVIDEND_WIDTH{1'b1}}, {DIVISOR_WIDTH{1'b0}}};
        end
    end

    always_ff @(posedge aclk) begin
        if (rst_i) begin
            for (int k = 0; k <= STAGES; k++) begin
                vld_q[k] <= 1'b0;
            end
            fix_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            vld_q[0] <= s_axis_divisor_tvalid & s_axis_dividend_tvalid;
            dvd_q[0] <= s_axis_dividend_tdata;
            dsr_q[0] <= s_axis_divisor_tdata;
            rem_q[0] <= '0;
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k+1] <= vld_q[k];
                dsr_q[k+1] <= dsr_q[k];
                rem_q[k+1] <= rem_d[k];
                dvd_q[k+1] <= {dvd_q[k][DIVIDEND_WIDTH-2:0], take_d[k]};
            end
            fix_vld_q  <= vld_q[STAGES];
            fix_data_q <= fix_data_d;
            out_vld_q  <= fix_vld_q;
            if (fix_vld_q) begin
                out_data_q <= fix_data_q;
            end
        end
    end

    assign m_axis_dout_tvalid = out_vld_q;
    assign m_axis_dout_tdata  = out_data_q;

endmodule

// File: tb/tb_low_pass_divider.sv
// Randomized scoreboard bench for low_pass_divider: the driver pushes expected
// {quotient, remainder} words with their due cycle; a monitor pops and compares.
module tb_low_pass_divider;
    localparam int LAT = 26;

    logic        aclk = 1'b0;
    logic        rst_i = 1'b1;
    logic        s_axis_divisor_tvalid = 1'b0;
    logic [7:0]  s_axis_divisor_tdata = '0;
    logic        s_axis_dividend_tvalid = 1'b0;
    logic [23:0] s_axis_dividend_tdata = '0;
    logic        m_axis_dout_tvalid;
    logic [31:0] m_axis_dout_tdata;

    low_pass_divider dut (
        .aclk                   (aclk),
        .rst_i                  (rst_i),
        .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
        .s_axis_divisor_tdata   (s_axis_divisor_tdata),
        .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
        .s_axis_dividend_tdata  (s_axis_dividend_tdata),
        .m_axis_dout_tvalid     (m_axis_dout_tvalid),
        .m_axis_dout_tdata      (m_axis_dout_tdata)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int          due_q[$];
    logic [31:0] last_exp = '0;
    int          total = 0;
    int          bad = 0;

    function automatic logic [31:0] model(input logic [23:0] a, input logic [7:0] b);
        logic [23:0] q;
        logic [7:0]  r;
        if (b == 0) return {24'hFFFFFF, 8'h00};
        q = 24'(a / b);
        r = 8'(a % b);
        return {q, r};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic va, input logic vb, input logic [23:0] a,
                         input logic [7:0] b, input logic use_exp, input logic [31:0] exp_word);
        @(negedge aclk);
        s_axis_dividend_tvalid = va;
        s_axis_divisor_tvalid  = vb;
        s_axis_dividend_tdata  = a;
        s_axis_divisor_tdata   = b;
        if (va && vb) begin
            exp_q.push_back(use_exp ? exp_word : model(a, b));
            due_q.push_back(cyc + 1 + LAT);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 24'($urandom), 8'($urandom), 1'b0, 32'h0);
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < LAT + 20) begin
            idle(1);
            waited++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge aclk) begin
        #1;
        if (m_axis_dout_tvalid) begin
            total++;
            if (exp_q.size() == 0 || due_q[0] != cyc) begin
                bad++;
                $display("FAIL unexpected_valid: cyc=%0d dout=%h due=%0d", cyc, m_axis_dout_tdata,
                         (due_q.size() != 0) ? due_q[0] : -1);
            end else begin
                last_exp = exp_q.pop_front();
                void'(due_q.pop_front());
                total++;
                if (m_axis_dout_tdata !== last_exp) begin
                    bad++;
                    $display("FAIL result: cyc=%0d got=%h required=%h", cyc, m_axis_dout_tdata, last_exp);
                end
            end
        end else begin
            if (due_q.size() != 0 && due_q[0] <= cyc) begin
                total++;
                bad++;
                $display("FAIL missing_valid: cyc=%0d got tvalid=0 required=1 data=%h", cyc, exp_q[0]);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            total++;
            if (m_axis_dout_tdata !== last_exp) begin
                bad++;
                $display("FAIL hold: cyc=%0d got=%h required=%h", cyc, m_axis_dout_tdata, last_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge aclk);
        total++;
        if (m_axis_dout_tvalid !== 1'b0 || m_axis_dout_tdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%h required v=0 d=0", m_axis_dout_tvalid, m_axis_dout_tdata);
        end
        rst_i = 1'b0;
        idle(2);

        // Directed values with hand-computed expectations.
        drive(1'b1, 1'b1, 24'd800, 8'd8, 1'b1, 32'h00006400);
        idle(1);
        drain();
        drive(1'b1, 1'b1, 24'hFFFFFF, 8'd8,   1'b1, 32'h1FFFFF07);
        drive(1'b1, 1'b1, 24'd1000,   8'd7,   1'b1, 32'h00008E06);
        drive(1'b1, 1'b1, 24'd5,      8'd200, 1'b1, 32'h00000005);
        drive(1'b1, 1'b1, 24'd1234,   8'd0,   1'b1, 32'hFFFFFF00);
        drive(1'b1, 1'b1, 24'(8 * 4660), 8'd8, 1'b1, 32'h00123400);
        drive(1'b1, 1'b1, 24'd7,      8'd7,   1'b1, 32'h00000100);
        // One-sided valids must produce nothing.
        drive(1'b1, 1'b0, 24'd99, 8'd3, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 24'd99, 8'd3, 1'b0, 32'h0);
        idle(1);
        drain();

        // 100 back-to-back random transactions.
        for (int i = 0; i < 100; i++) begin
            logic [7:0] b;
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            drive(1'b1, 1'b1, 24'($urandom_range(0, 24'hFFFFFF)), b, 1'b0, 32'h0);
        end
        drain();

        // Gapped pattern including one-sided valids.
        for (int i = 0; i < 80; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  24'($urandom), 8'($urandom_range(0, 255)), 1'b0, 32'h0);
        end
        drain();

        // Reset mid-flight: ten transactions, reset on the fifth in-flight cycle.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 24'($urandom), 8'($urandom_range(1, 255)), 1'b0, 32'h0);
        end
        idle(4);
        @(negedge aclk);
        s_axis_dividend_tvalid = 1'b1;
        s_axis_divisor_tvalid  = 1'b1;
        rst_i = 1'b1;
        exp_q.delete();
        due_q.delete();
        last_exp = '0;
        @(negedge aclk);
        rst_i = 1'b0;
        s_axis_dividend_tvalid = 1'b0;
        s_axis_divisor_tvalid  = 1'b0;
        total++;
        if (m_axis_dout_tvalid !== 1'b0 || m_axis_dout_tdata !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset: got v=%b d=%h required v=0 d=0", m_axis_dout_tvalid, m_axis_dout_tdata);
        end
        idle(LAT + 5);
        drive(1'b1, 1'b1, 24'd1000, 8'd7, 1'b1, 32'h00008E06);
        idle(1);
        drain();
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/low_pass_divider.md
Name: low_pass_divider

Overview:
- Fully pipelined unsigned integer divider with AXI-stream-style inputs and no back-pressure.
- Accepts a 24-bit dividend and an 8-bit divisor per cycle.
- Returns quotient and remainder packed into a 32-bit word after a fixed latency.
- Used by the moving-average low-pass filter to divide the window sum by the window depth; the filter takes dout[23:8].

Parameters:
DIVIDEND_WIDTH, 24, unsigned dividend width
DIVISOR_WIDTH, 8, unsigned divisor width
LATENCY, DIVIDEND_WIDTH+2 (26), fixed input-to-output cycles; derived value, not overridable

Ports:
aclk  input  1  clock; all logic on rising edge
rst_i  input  1  synchronous active-high reset
s_axis_divisor_tvalid  input  1  divisor valid
s_axis_divisor_tdata  input  DIVISOR_WIDTH (8)  unsigned divisor
s_axis_dividend_tvalid  input  1  dividend valid
s_axis_dividend_tdata  input  DIVIDEND_WIDTH (24)  unsigned dividend
m_axis_dout_tvalid  output  1  result valid, one-cycle pulse per transaction
m_axis_dout_tdata  output  32  {quotient[23:0], remainder[7:0]}

Behaviour:
- Interface: one clock, synchronous active-high reset.
- No tready on any interface. The block is always ready, and the output cannot be stalled.
- Transaction acceptance:
  - A transaction is accepted on a rising edge when both s_axis_divisor_tvalid and s_axis_dividend_tvalid are 1.
  - If only one valid is high, nothing is accepted and no data is buffered; that operand is discarded.
- Throughput: one transaction per cycle, so back-to-back transactions are supported indefinitely.
- Latency:
  - A transaction accepted at edge N produces m_axis_dout_tvalid=1 with its result registered at edge N+26.
  - Pipeline: 1 input register stage, 24 radix-2 restoring-division stages (one quotient bit each, MSB first), 1 output register.
- Ordering: results emerge in acceptance order, and the valid pattern is the input acceptance pattern delayed by 26 cycles.
- Arithmetic (all unsigned):
  - quotient = floor(dividend/divisor), 24 bits.
  - remainder = dividend mod divisor, 8 bits; always < divisor.
  - The partial remainder inside each stage is DIVISOR_WIDTH+1 bits wide so the trial subtraction cannot overflow.
- Output packing: m_axis_dout_tdata[31:8] = quotient, [7:0] = remainder.
- Divide by zero (divisor=0): quotient = 24'hFFFFFF, remainder = 8'h00, tvalid asserted normally. There is no error flag.
- Output hold: m_axis_dout_tdata holds the last result while tvalid=0.
- Reset:
  - While rst_i=1, all pipeline valid bits clear, m_axis_dout_tvalid=0 and m_axis_dout_tdata=0.
  - Inputs presented during reset are not accepted.
  - Reset mid-operation discards every in-flight transaction; no stale tvalid appears after reset is released.
  - The first transaction accepted after release emerges 26 cycles later.
- Power-up: before any reset, all registers initialise to 0.

Test Plan:
- Dividend 800, divisor 8, single pulse -> 26 cycles later tvalid pulses for one cycle with dout=32'h00006400, so [23:8]=16'h0064.
- Dividend 24'hFFFFFF, divisor 8 -> dout=32'h1FFFFF07. Dividend 1000, divisor 7 -> dout=32'h00008E06. Dividend 5, divisor 200 -> dout=32'h00000005.
- 100 back-to-back transactions with random operands -> 100 consecutive valid cycles starting 26 cycles after the first, each matching the golden {q,r}. A gapped valid pattern reproduces the identical gap pattern.
- Divisor 0, dividend 1234 -> dout=32'hFFFFFF00 with tvalid. Dividend valid without divisor valid, and the reverse -> no output pulse.
- Issue 10 transactions, assert rst_i for 1 cycle at the 5th in-flight cycle -> tvalid stays 0 for all 10 and dout=0. A new transaction after reset returns the correct result at +26.
- Window-sum use: dividend 8*4660, divisor 8 -> dout[23:8]=16'h1234 and remainder 0.
